// File: rtl/input_loader.sv
// Host byte stream to 12-bit buffer refill stage: packs 3 bytes into 2 words per group.
// Optional block checksum on blk_sum when INPUT_LOADER_CKSUM_EN is defined (else tied to 0).
module input_loader #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              in1_rdy,
  output logic              in1_write,
  output logic [ADDR_W-1:0] addr_in,
  output logic [11:0]       data_in,
  output logic              loading,
  output logic              blk_done,
  output logic [11:0]       blk_sum
);

  typedef enum logic [2:0] {
    FILL_B0,
    FILL_B1,
    FILL_B2,
    DRAIN,
    WAIT_REQ
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_b0;
  logic [3:0]        r_w1_lo;
  logic              r_drain_cnt;
  logic              r_byte_ready;
  logic              r_loading;
  logic              r_in1_write;
  logic              r_blk_done;
  logic [ADDR_W-1:0] r_addr_in;
  logic [11:0]       r_data_in;

  logic              w_xfer;
  logic [11:0]       w_w0;
  logic [11:0]       w_w1;

  assign w_xfer = byte_valid & r_byte_ready;
  assign w_w0   = {byte_data[3:0], r_b0};
  assign w_w1   = {byte_data, r_w1_lo};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= FILL_B0;
      r_addr       <= '0;
      r_b0         <= '0;
      r_w1_lo      <= '0;
      r_drain_cnt  <= 1'b0;
      r_byte_ready <= 1'b1;
      r_loading    <= 1'b1;
      r_in1_write  <= 1'b0;
      r_blk_done   <= 1'b0;
      r_addr_in    <= '0;
      r_data_in    <= '0;
    end else begin
      // NOTE: strobes default low each cycle so a stall can never repeat a write.
      r_in1_write <= 1'b0;
      r_blk_done  <= 1'b0;
      unique case (r_state)
        FILL_B0: if (w_xfer) begin
          r_b0    <= byte_data;
          r_state <= FILL_B1;
        end
        FILL_B1: if (w_xfer) begin
          r_w1_lo     <= byte_data[7:4];
          r_in1_write <= 1'b1;
          r_addr_in   <= r_addr;
          r_data_in   <= w_w0;
          r_addr      <= r_addr + ADDR_W'(1);
          r_state     <= FILL_B2;
        end
        FILL_B2: if (w_xfer) begin
          r_in1_write <= 1'b1;
          r_addr_in   <= r_addr;
          r_data_in   <= w_w1;
          if (r_addr == LAST_ADDR) begin
            // Address is held here; it only returns to 0 when a new block is requested.
            r_blk_done   <= 1'b1;
            r_drain_cnt  <= 1'b0;
            r_byte_ready <= 1'b0;
            r_loading    <= 1'b0;
            r_state      <= DRAIN;
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_state <= FILL_B0;
          end
        end
        DRAIN: begin
          r_drain_cnt <= 1'b1;
          if (r_drain_cnt) r_state <= WAIT_REQ;
        end
        WAIT_REQ: if (in1_rdy) begin
          r_addr       <= '0;
          r_byte_ready <= 1'b1;
          r_loading    <= 1'b1;
          r_state      <= FILL_B0;
        end
        default: begin
          r_byte_ready <= 1'b0;
          r_loading    <= 1'b0;
          r_state      <= WAIT_REQ;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign loading    = r_loading;
  assign in1_write  = r_in1_write;
  assign addr_in    = r_addr_in;
  assign data_in    = r_data_in;
  assign blk_done   = r_blk_done;

`ifdef INPUT_LOADER_CKSUM_EN
  logic [11:0] r_acc;
  logic [11:0] r_blk_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_blk_sum <= '0;
    end else if (r_state == WAIT_REQ && in1_rdy) begin
      r_acc <= '0;
    end else if (w_xfer && r_state == FILL_B1) begin
      r_acc <= r_acc + w_w0;
    end else if (w_xfer && r_state == FILL_B2) begin
      r_acc <= r_acc + w_w1;
      // Publish together with blk_done, including the final word.
      if (r_addr == LAST_ADDR) r_blk_sum <= r_acc + w_w1;
    end
  end

  assign blk_sum = r_blk_sum;
`else
  assign blk_sum = 12'h000;
`endif

endmodule
